// File: rtl/mem_access_unit.sv
// Load/store unit: converts byte/halfword/word CPU accesses into 32-bit word memory accesses.
// Define MAU_ALIGN_CHECK_EN to trap misaligned accesses instead of silently aligning them.
module mem_access_unit #(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_write,
    input  logic [31:0]       mem_dout,
    input  logic              mem_busy
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, DONE} state_t;

    state_t      state;
    logic        r_we;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic [1:0]  req_off;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    // Byte offset of the request with the low bits a wider access cannot use cleared
    always_comb begin
        req_off = 2'b00;
        if (size == SZ_BYTE) begin
            req_off = addr[1:0];
        end else if (size == SZ_HALF) begin
            req_off = {addr[1], 1'b0};
        end
    end

    assign byte_lane = BIG_ENDIAN ? ~r_off : r_off;
    assign half_lane = BIG_ENDIAN ? ~r_off[1] : r_off[1];

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        ld_byte = mem_dout[{byte_lane, 3'b000} +: 8];
        ld_half = mem_dout[{half_lane, 4'b0000} +: 16];
        case (r_size)
            SZ_BYTE: ld_ext = {{24{r_sign & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{r_sign & ld_half[15]}}, ld_half};
            default: ld_ext = mem_dout;
        endcase
        st_merge = mem_dout;
        if (r_size == SZ_BYTE) begin
            st_merge[{byte_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_size == SZ_HALF) begin
            st_merge[{half_lane, 4'b0000} +: 16] = r_wdata;
        end
    end

`ifdef MAU_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign addr_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= 32'h0;
            mem_addr  <= '0;
            mem_din   <= 32'h0;
            r_we      <= 1'b0;
            r_sign    <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= 2'b00;
            r_wdata   <= 16'h0;
`ifdef MAU_ALIGN_CHECK_EN
            addr_error <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
            addr_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_sign   <= sign_ext;
                        r_size   <= size;
                        r_off    <= req_off;
                        r_wdata  <= wdata[15:0];
                        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                        busy     <= 1'b1;
`ifdef MAU_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            addr_error <= 1'b1;
                        end else
`endif
                        if (we && size[1]) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_din   <= wdata;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    if (!mem_busy) begin
                        if (r_we) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_din   <= st_merge;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            rdata <= ld_ext;
                        end
                    end
                end
                WR: begin
                    if (!mem_busy) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_write <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU load/store stage and the data port of the unified memory.
- Converts byte, halfword and word loads and stores into the 32-bit word accesses the memory supports.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Holds the CPU stalled through `busy` until the access completes.

Parameters:
- BIG_ENDIAN, 0, byte-lane order: 0 = lane (addr[1:0]) is little-endian; 1 = lane 3-addr[1:0].
- ADDR_W, 32, virtual address width; upper bits pass through unchanged.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  CPU access request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address from CPU
- wdata  in  32  store data, right-aligned
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when access completes
- rdata  out  32  extended load result, valid while done=1 and held until next done
- addr_error  out  1  one-cycle pulse with done on misaligned access (feature-dependent)
- mem_addr  out  ADDR_W  word address to memory: addr with [1:0]=00
- mem_din  out  32  write data to memory
- mem_write  out  1  memory write enable
- mem_dout  in  32  memory read data, valid the cycle after mem_addr is presented
- mem_busy  in  1  memory stall; the current state holds while high

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, addr_error=0, mem_write=0, rdata=0, mem_addr=0, mem_din=0.
- IDLE: when req=1, register we, size, sign_ext, addr and wdata.
  - Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) with the check enabled: go to DONE with addr_error set. No memory access occurs.
  - Otherwise: load or sub-word store goes to RD; word store goes to WR.
- RD: drive mem_addr, mem_write=0. Go to RD_CAP unconditionally.
- RD_CAP: hold mem_addr.
  - If mem_busy=0, capture mem_dout into a word register.
  - Load: extract the lane, extend, and register into rdata; go to DONE.
  - Sub-word store: go to WR.
  - If mem_busy=1, stay in RD_CAP.
- WR: mem_write=1, mem_addr as above.
  - mem_din = wdata for a word store.
  - For a sub-word store, mem_din = captured word with only the selected byte/halfword lane replaced by wdata[7:0]/[15:0].
  - Stay while mem_busy=1; when mem_busy=0, go to DONE.
  - mem_write is high only in WR.
- DONE: done=1 for exactly one cycle, then go to IDLE. A new req is accepted in the IDLE cycle that follows, never in DONE.
- Latency from the edge sampling req to done high:
  - word store 2 cycles
  - load 3 cycles
  - sub-word store 4 cycles
  - misaligned 1 cycle
  - each mem_busy cycle adds 1.
- req while busy=1 is ignored and not queued.
- Lane extraction (little-endian):
  - byte = word[8*a+7 : 8*a] with a = addr[1:0]
  - halfword = word[16*addr[1]+15 : 16*addr[1]]
  - Extension uses bit 7 or bit 15 of the extracted value.
- Word loads ignore sign_ext.
- reset=1 at any edge forces IDLE regardless of state. A write in progress is abandoned: mem_write is low from the following cycle and no done is issued.
- mem_addr/mem_din are registered, so they are stable for the whole RD/RD_CAP/WR span.

Optional Feature:
- MAU_ALIGN_CHECK_EN defined: misaligned accesses take IDLE->DONE with addr_error=1 and no memory traffic.
- Not defined: addr_error is tied 0, and misaligned addresses are silently aligned:
  - halfword clears addr[0]
  - word clears addr[1:0]
  - the access then proceeds normally.

Test Plan:
- After reset, word store addr=0x1000_0004, wdata=0xDEADBEEF, mem_busy=0 -> mem_write=1 for one cycle with mem_addr=0x1000_0004; done 2 cycles after req.
- Preload 0x1122_3344 at 0x1000_0008; lb addr=0x1000_000B, sign_ext=1 -> rdata=0x0000_0011; lh addr=0x1000_0008, sign_ext=1 with word 0x0000_F0F0 -> rdata=0xFFFF_F0F0; done 3 cycles after req.
- Preload 0xAABB_CCDD; sb addr offset 1, wdata=0x55 -> written word 0xAABB_55DD; sh offset 2, wdata=0x1234 -> 0x1234_55DD; done 4 cycles after req.
- mem_busy held high 3 cycles during RD_CAP of a load -> done delayed by 3; rdata correct; mem_addr stable throughout.
- With MAU_ALIGN_CHECK_EN, lw addr=0x1000_0002 -> done+addr_error next cycle, no mem_write. Without the macro -> access at 0x1000_0000, addr_error=0.
- Assert reset in WR state of a sub-word store -> next cycle busy=0, mem_write=0, no done; a following req is accepted normally.
